// File: rtl/rv32e_exec_core.sv
// rv32e_exec_core: multi-cycle RV32E execute core (decode, 16x32 regfile, ALU, 4-state FSM).
// Define RV32E_ITYPE_EN to execute OP-IMM (0010011); otherwise those instructions trap as illegal.
module rv32e_exec_core #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     INSTR,
    output logic [XLEN-1:0] ALUResult,
    output logic            illegal,
    output logic            done
);

    localparam int RW = $clog2(REG_COUNT);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
`ifdef RV32E_ITYPE_EN
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
`endif

    typedef enum logic [1:0] {
        S_FETCH,
        S_READ,
        S_EXEC,
        S_WB
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    state_t          state_q, state_d;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] op1_q, op2_q;
    logic [XLEN-1:0] alu_q;
    logic            illegal_q;
    logic [XLEN-1:0] rf_q [REG_COUNT];

    logic [6:0] opcode;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_q[6:0];
    assign rd_f   = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign rs1_f  = instr_q[19:15];
    assign rs2_f  = instr_q[24:20];
    assign funct7 = instr_q[31:25];

    alu_op_t alu_op;
    logic    dec_bad;
    logic    use_rs2;
    logic    reg_bad;
    logic    dec_ill;

    always_comb begin
        alu_op  = ALU_ADD;
        dec_bad = 1'b1;
        use_rs2 = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                use_rs2 = 1'b1;
                dec_bad = 1'b0;
                unique case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         dec_bad = 1'b1;
                endcase
            end
`ifdef RV32E_ITYPE_EN
            OPC_OPIMM: begin
                dec_bad = 1'b0;
                unique case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        alu_op  = ALU_SLL;
                        dec_bad = (funct7 != 7'h00);
                    end
                    3'b101: begin
                        alu_op  = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        dec_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
`endif
            default: dec_bad = 1'b1;
        endcase
    end

    // rs2 bits hold the immediate for OP-IMM, so only range-check it for R-type
    always_comb begin
        reg_bad = (int'(rd_f) >= REG_COUNT) || (int'(rs1_f) >= REG_COUNT);
        if (use_rs2 && int'(rs2_f) >= REG_COUNT) begin
            reg_bad = 1'b1;
        end
    end

    assign dec_ill = dec_bad || reg_bad;

    logic [XLEN-1:0] rs1_val, rs2_val, op2_sel;

    assign rs1_val = (rs1_f[RW-1:0] == '0) ? '0 : rf_q[rs1_f[RW-1:0]];
    assign rs2_val = (rs2_f[RW-1:0] == '0) ? '0 : rf_q[rs2_f[RW-1:0]];

`ifdef RV32E_ITYPE_EN
    logic [XLEN-1:0] imm_sext;
    assign imm_sext = {{(XLEN-12){instr_q[31]}}, instr_q[31:20]};
    assign op2_sel  = (opcode == OPC_OPIMM) ? imm_sext : rs2_val;
`else
    assign op2_sel  = rs2_val;
`endif

    logic [4:0]      shamt;
    logic [XLEN-1:0] alu_out;

    assign shamt = op2_q[4:0];

    always_comb begin
        alu_out = '0;
        unique case (alu_op)
            ALU_ADD:  alu_out = op1_q + op2_q;
            ALU_SUB:  alu_out = op1_q - op2_q;
            ALU_SLL:  alu_out = op1_q << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}},
                                 ($signed(op1_q) < $signed(op2_q))};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, (op1_q < op2_q)};
            ALU_XOR:  alu_out = op1_q ^ op2_q;
            ALU_SRL:  alu_out = op1_q >> shamt;
            ALU_SRA:  alu_out = $signed(op1_q) >>> shamt;
            ALU_OR:   alu_out = op1_q | op2_q;
            ALU_AND:  alu_out = op1_q & op2_q;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            S_FETCH: state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                done    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_FETCH: instr_q <= INSTR;
                S_READ: begin
                    op1_q <= rs1_val;
                    op2_q <= op2_sel;
                end
                S_EXEC: begin
                    alu_q     <= dec_ill ? '0 : alu_out;
                    illegal_q <= dec_ill;
                end
                default: ;
            endcase
        end
    end

    // x0 is never written; reads of index 0 are forced to zero as well
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
        end else if (state_q == S_WB && !illegal_q && rd_f[RW-1:0] != '0) begin
            rf_q[rd_f[RW-1:0]] <= alu_q;
        end
    end

    assign ALUResult = alu_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32e_exec_core.sv
// tb_rv32e_exec_core: random + directed checks of rv32e_exec_core against a mnemonic-level model.
// Model honours RV32E_ITYPE_EN the same way the design build does.
module tb_rv32e_exec_core;

    logic        clk;
    logic        reset;
    logic [31:0] INSTR;
    logic [31:0] ALUResult;
    logic        illegal;
    logic        done;

    int total;
    int bad;

`ifdef RV32E_ITYPE_EN
    localparam bit ITYPE_EN = 1'b1;
`else
    localparam bit ITYPE_EN = 1'b0;
`endif

    rv32e_exec_core dut (
        .clk       (clk),
        .reset     (reset),
        .INSTR     (INSTR),
        .ALUResult (ALUResult),
        .illegal   (illegal),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mregs [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_exec(input logic [31:0] ins,
                                     output logic [31:0] res,
                                     output logic ill,
                                     output logic [3:0] wr_idx,
                                     output logic wen);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          rd, rs1, rs2, sh;
        bit          rtype;
        string       m;
        logic [31:0] a, b;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        rd    = int'(ins[11:7]);
        rs1   = int'(ins[19:15]);
        rs2   = int'(ins[24:20]);
        rtype = (opc == 7'h33);
        m     = "";
        if (rtype) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: m = "ADD";
                    3'd1: m = "SLL";
                    3'd2: m = "SLT";
                    3'd3: m = "SLTU";
                    3'd4: m = "XOR";
                    3'd5: m = "SRL";
                    3'd6: m = "OR";
                    default: m = "AND";
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) m = "SUB";
            else if (f7 == 7'h20 && f3 == 3'd5) m = "SRA";
        end else if (opc == 7'h13 && ITYPE_EN) begin
            case (f3)
                3'd0: m = "ADD";
                3'd2: m = "SLT";
                3'd3: m = "SLTU";
                3'd4: m = "XOR";
                3'd6: m = "OR";
                3'd7: m = "AND";
                3'd1: if (f7 == 7'h00) m = "SLL";
                default: begin
                    if (f7 == 7'h00) m = "SRL";
                    else if (f7 == 7'h20) m = "SRA";
                end
            endcase
        end
        ill = (m == "") || rd > 15 || rs1 > 15 || (rtype && rs2 > 15);
        res = 32'd0;
        wen = 1'b0;
        wr_idx = 4'(rd);
        if (!ill) begin
            a  = mregs[rs1];
            b  = rtype ? mregs[rs2] : {{20{ins[31]}}, ins[31:20]};
            sh = int'(b % 32);
            if (m == "ADD") res = a + b;
            else if (m == "SUB") res = a - b;
            else if (m == "SLL") res = a << sh;
            else if (m == "SLT") res = ($signed(a) < $signed(b)) ? 1 : 0;
            else if (m == "SLTU") res = (a < b) ? 1 : 0;
            else if (m == "XOR") res = a ^ b;
            else if (m == "SRL") res = a >> sh;
            else if (m == "SRA") res = 32'($signed(a) >>> sh);
            else if (m == "OR") res = a | b;
            else res = a & b;
            wen = (rd != 0);
        end
    endfunction

    // called with the FSM in FETCH; leaves it in FETCH again
    task automatic run_instr(input logic [31:0] ins, output logic [31:0] got);
        logic [31:0] er;
        logic        ei, we;
        logic [3:0]  wi;
        ref_exec(ins, er, ei, wi, we);
        INSTR = ins;
        repeat (3) @(posedge clk);
        #1;
        got = ALUResult;
        chk("result", ALUResult, er);
        chk("illegal", {31'd0, illegal}, {31'd0, ei});
        chk("done_wb", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        chk("done_low", {31'd0, done}, 32'd0);
        if (we) mregs[wi] = er;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        int         sel, k;
        logic [6:0] r_f7 [10];
        logic [2:0] r_f3 [10];
        r_f7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00,
                 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
        r_f3 = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
                 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        sel = int'($urandom_range(0, 99));
        if (sel < 45) begin
            k = int'($urandom_range(0, 9));
            return {r_f7[k], rs2, rs1, r_f3[k], rd, 7'h33};
        end else if (sel < 85) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'($urandom);
            if (f3 == 3'd1 || f3 == 3'd5)
                f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            return {f7, 5'($urandom), rs1, f3, rd, 7'h13};
        end else if (sel < 93) begin
            k = int'($urandom_range(0, 9));
            case ($urandom_range(0, 2))
                0: rd  = 5'($urandom_range(16, 31));
                1: rs1 = 5'($urandom_range(16, 31));
                default: rs2 = 5'($urandom_range(16, 31));
            endcase
            return {r_f7[k], rs2, rs1, r_f3[k], rd, 7'h33};
        end
        return $urandom;
    endfunction

    logic [31:0] got;
    logic [31:0] seq [6];

    initial begin
        total = 0;
        bad   = 0;
        foreach (mregs[i]) mregs[i] = 32'd0;
        reset = 1'b1;
        INSTR = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        seq = '{32'h00500093, 32'h00108133, 32'h401001B3,
                32'h4011D213, 32'h0030B2B3, 32'h00700013};
        foreach (seq[i]) run_instr(seq[i], got);
`ifdef RV32E_ITYPE_EN
        chk("spec_x1", mregs[1], 32'd5);
        chk("spec_x3", mregs[3], 32'hFFFFFFFB);
        chk("spec_x4", mregs[4], 32'hFFFFFFFD);
        chk("spec_x5", mregs[5], 32'd1);
        chk("spec_addi_x0", got, 32'd7);
`else
        chk("spec_x1_noimm", mregs[1], 32'd0);
        chk("spec_addi_x0_noimm", got, 32'd0);
`endif
        run_instr(32'h00000133, got);
        chk("x0_reads_zero", got, 32'd0);
        run_instr(32'h00000833, got);
        chk("rd16_result", got, 32'd0);
        chk("rd16_illegal", {31'd0, illegal}, 32'd1);

        for (int n = 0; n < 400; n++) begin
            run_instr(rand_instr(), got);
        end
        for (int k = 0; k < 16; k++) begin
            run_instr({7'h00, 5'd0, 5'(k), 3'b110, 5'd0, 7'h33}, got);
        end

        // reset during EXEC of an instruction that would write x6
        run_instr(32'h00500093, got);
        INSTR = 32'h00108333;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_result", ALUResult, 32'd0);
        chk("midrst_illegal", {31'd0, illegal}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        foreach (mregs[i]) mregs[i] = 32'd0;
        run_instr({7'h00, 5'd0, 5'd6, 3'b110, 5'd0, 7'h33}, got);
        chk("midrst_x6", got, 32'd0);
        for (int n = 0; n < 100; n++) begin
            run_instr(rand_instr(), got);
        end
        for (int k = 0; k < 16; k++) begin
            run_instr({7'h00, 5'd0, 5'(k), 3'b110, 5'd0, 7'h33}, got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
